// File: rtl/systolic_result_streamer.sv
// Drain stage for the systolic array: captures the N x N result matrix on a result pulse
// and streams it row-major, one element per valid/ready beat, flagging dropped results.
module systolic_result_streamer #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
) (
  input  logic                          i_clk,
  input  logic                          i_arst,
  input  logic [N-1:0][N-1:0][W-1:0]    i_c,
  input  logic                          i_validResult,
  output logic                          o_idle,
  output logic [W-1:0]                  o_data,
  output logic [$clog2(N)-1:0]          o_row,
  output logic [$clog2(N)-1:0]          o_col,
  output logic                          o_valid,
  output logic                          o_last,
  input  logic                          i_ready,
  output logic                          o_overflow,
  input  logic                          i_clearOverflow
);

  localparam int unsigned NN = N * N;
  localparam int unsigned IW = $clog2(NN);
  localparam int unsigned RW = $clog2(N);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                       state, state_next;
  logic [IW-1:0]                idx, idx_next;
  logic [N-1:0][N-1:0][W-1:0]   buffer;
  logic                         capture;
  logic                         ovf_set;
  logic                         is_last;
  logic                         fire;
  logic [RW-1:0]                row, col;

  assign o_valid = (state == STREAM);
  assign o_idle  = (state == IDLE);
  assign is_last = (idx == IW'(NN - 1));
  assign o_last  = is_last & o_valid;
  assign fire    = o_valid & i_ready;

  assign row    = RW'(idx / IW'(N));
  assign col    = RW'(idx % IW'(N));
  assign o_row  = row;
  assign o_col  = col;
  assign o_data = buffer[row][col];

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_next = state;
    idx_next   = idx;
    capture    = 1'b0;
    ovf_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_validResult) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (fire) begin
          if (is_last) begin
            idx_next = '0;
            if (i_validResult) capture    = 1'b1;
            else               state_next = IDLE;
          end else begin
            idx_next = idx + IW'(1);
          end
        end
        // A pulse is only accepted when it lands exactly on the final handshake.
        if (i_validResult && !(fire && is_last)) ovf_set = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state      <= IDLE;
      idx        <= '0;
      // NOTE: the buffer is reset so o_data reads zero out of reset rather than X.
      buffer     <= '0;
      o_overflow <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (capture) buffer <= i_c;
      if (ovf_set)              o_overflow <= 1'b1;
      else if (i_clearOverflow) o_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_result_streamer.sv
// Directed bench for systolic_result_streamer: drain, backpressure, overflow,
// back-to-back matrices and mid-stream reset, checked with immediate assertions.
module tb_systolic_result_streamer;

  typedef logic [3:0][3:0][15:0] mat_t;

  logic        clk = 1'b0;
  logic        arst;
  mat_t        c_in;
  logic        valid_result;
  logic        idle;
  logic [15:0] data;
  logic [1:0]  row, col;
  logic        valid, last, ready, overflow, clear_ovf;

  int vectors = 0;
  int errors  = 0;

  systolic_result_streamer #(.N(4), .W(16)) dut (
    .i_clk           (clk),
    .i_arst          (arst),
    .i_c             (c_in),
    .i_validResult   (valid_result),
    .o_idle          (idle),
    .o_data          (data),
    .o_row           (row),
    .o_col           (col),
    .o_valid         (valid),
    .o_last          (last),
    .i_ready         (ready),
    .o_overflow      (overflow),
    .i_clearOverflow (clear_ovf)
  );

  always #5 clk = ~clk;

  function automatic mat_t make_mat(input logic [15:0] base);
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = base + 16'(4 * r + c);
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input int k, input logic [15:0] exp_data, input logic exp_last);
    check({tag, " valid"}, 32'(valid), 32'd1);
    check({tag, " data"},  32'(data), 32'(exp_data));
    check({tag, " row"},   32'(row), 32'(k / 4));
    check({tag, " col"},   32'(col), 32'(k % 4));
    check({tag, " last"},  32'(last), 32'(exp_last));
    check({tag, " idle"},  32'(idle), 32'd0);
  endtask

  task automatic pulse(input mat_t m);
    c_in = m;
    valid_result = 1'b1;
    tick();
    valid_result = 1'b0;
    c_in = {16{16'hDEAD}};
  endtask

  initial begin
    arst = 1'b1;
    c_in = '0;
    valid_result = 1'b0;
    ready = 1'b1;
    clear_ovf = 1'b0;
    #1;
    // Reset state
    check("rst valid", 32'(valid), 32'd0);
    check("rst last", 32'(last), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst idle", 32'(idle), 32'd1);
    check("rst data", 32'(data), 32'd0);
    check("rst row", 32'(row), 32'd0);
    check("rst col", 32'(col), 32'd0);
    #12;
    arst = 1'b0;
    tick();

    // 1: full drain with ready held high
    ready = 1'b1;
    pulse(make_mat(16'h0100));
    for (int k = 0; k < 16; k++) begin
      check_beat("t1", k, 16'h0100 + 16'(k), k == 15);
      tick();
    end
    check("t1 end valid", 32'(valid), 32'd0);
    check("t1 end idle", 32'(idle), 32'd1);
    check("t1 end last", 32'(last), 32'd0);

    // 2: alternating ready, 16 beats over 31 cycles
    begin
      int k = 0;
      pulse(make_mat(16'h0100));
      for (int cyc = 0; cyc < 31; cyc++) begin
        ready = (cyc % 2 == 0);
        check_beat("t2", k, 16'h0100 + 16'(k), k == 15);
        tick();
        if (ready) k++;
      end
      check("t2 beats", 32'(k), 32'd16);
      check("t2 end idle", 32'(idle), 32'd1);
      ready = 1'b1;
    end

    // 3: overflow pulse at beat 5, then clear
    pulse(make_mat(16'h0100));
    for (int k = 0; k < 16; k++) begin
      check_beat("t3", k, 16'h0100 + 16'(k), k == 15);
      check("t3 overflow", 32'(overflow), 32'(k >= 6));
      if (k == 5) begin
        c_in = {16{16'hFFFF}};
        valid_result = 1'b1;
      end
      tick();
      valid_result = 1'b0;
      c_in = {16{16'hDEAD}};
    end
    check("t3 end idle", 32'(idle), 32'd1);
    check("t3 end overflow", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("t3 cleared", 32'(overflow), 32'd0);

    // 4: back-to-back matrices with the second pulse on the last transfer
    pulse(make_mat(16'h0100));
    for (int k = 0; k < 32; k++) begin
      check_beat("t4", k % 16, (k < 16) ? 16'h0100 + 16'(k) : 16'h0200 + 16'(k - 16),
                 (k == 15) || (k == 31));
      check("t4 overflow", 32'(overflow), 32'd0);
      if (k == 15) begin
        c_in = make_mat(16'h0200);
        valid_result = 1'b1;
      end
      tick();
      valid_result = 1'b0;
      c_in = {16{16'hDEAD}};
    end
    check("t4 end idle", 32'(idle), 32'd1);

    // 6: clear coincident with a fresh overflow pulse, set wins
    pulse(make_mat(16'h0100));
    for (int k = 0; k < 16; k++) begin
      check_beat("t6", k, 16'h0100 + 16'(k), k == 15);
      check("t6 overflow", 32'(overflow), 32'(k >= 4));
      valid_result = (k == 3) || (k == 8);
      clear_ovf    = (k == 8);
      tick();
      valid_result = 1'b0;
      clear_ovf = 1'b0;
    end
    check("t6 end overflow", 32'(overflow), 32'd1);

    // 5: async reset while beat 7 is presented (overflow still set from above)
    pulse(make_mat(16'h0100));
    for (int k = 0; k < 7; k++) tick();
    check_beat("t5 pre", 7, 16'h0107, 1'b0);
    #2;
    arst = 1'b1;
    #1;
    check("t5 rst valid", 32'(valid), 32'd0);
    check("t5 rst overflow", 32'(overflow), 32'd0);
    check("t5 rst last", 32'(last), 32'd0);
    check("t5 rst data", 32'(data), 32'd0);
    #3;
    arst = 1'b0;
    tick();
    check("t5 idle", 32'(idle), 32'd1);
    check("t5 valid", 32'(valid), 32'd0);
    pulse(make_mat(16'h0300));
    for (int k = 0; k < 16; k++) begin
      check_beat("t5 restart", k, 16'h0300 + 16'(k), k == 15);
      tick();
    end
    check("t5 end idle", 32'(idle), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
